// File: rtl/simple_bus_master.sv
// Command-queued initiator for the simple ADDR/WE/WD/RD register bus.
// Define SIMPLE_BUS_MASTER_POLL_EN to enable poll commands (op 2); otherwise op 2 returns an error.
module simple_bus_master #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int FIFO_D   = 4,
   parameter int POLL_TMO = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VLD,
   output logic              CMD_RDY,
   input  logic [1:0]        CMD_OP,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [DATA_W-1:0] CMD_WD,
   input  logic [DATA_W-1:0] CMD_MASK,
   output logic              RSP_VLD,
   input  logic              RSP_RDY,
   output logic [DATA_W-1:0] RSP_DATA,
   output logic              RSP_ERR,
   output logic [ADDR_W-1:0] ADDR,
   output logic              WE,
   output logic [DATA_W-1:0] WD,
   input  logic [DATA_W-1:0] RD
);

   localparam int AW_P = $clog2(FIFO_D);
   localparam int PW   = AW_P + 1;

   typedef struct packed {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
`ifdef SIMPLE_BUS_MASTER_POLL_EN
      logic [DATA_W-1:0] mask;
`endif
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_n;
   cmd_t              mem [FIFO_D];
   cmd_t              push_cmd;
   cmd_t              wk;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              full, empty, push, pop;
   logic              capture, cap_err;
   logic [DATA_W-1:0] cap_data;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign CMD_RDY = !full;
   assign push    = CMD_VLD && !full;
   assign pop     = (state == IDLE) && !empty;

   always_comb begin
      push_cmd      = '0;
      push_cmd.op   = CMD_OP;
      push_cmd.addr = CMD_ADDR;
      push_cmd.wd   = CMD_WD;
`ifdef SIMPLE_BUS_MASTER_POLL_EN
      push_cmd.mask = CMD_MASK;
`endif
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[AW_P-1:0]] <= push_cmd;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

`ifdef SIMPLE_BUS_MASTER_POLL_EN
   localparam int CW = $clog2(POLL_TMO + 1);
   logic [CW-1:0] cnt;
   logic          cnt_inc;
   logic          poll_hit, poll_last;

   assign poll_hit  = ((RD ^ wk.wd) & wk.mask) == '0;
   // cnt holds the number of reads already done, so this read is number cnt+1.
   assign poll_last = (cnt == CW'(POLL_TMO - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)         cnt <= '0;
      else if (pop)     cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
   end
`else
   logic unused_mask;
   assign unused_mask = ^CMD_MASK;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (!empty) state_n = ACCESS;
         ACCESS: begin
            case (wk.op)
               2'd0: state_n = IDLE;
               2'd1: state_n = RESP;
`ifdef SIMPLE_BUS_MASTER_POLL_EN
               2'd2: if (poll_hit || poll_last) state_n = RESP;
`endif
               default: state_n = RESP;
            endcase
         end
         RESP:   if (RSP_RDY) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ADDR     = '0;
      WD       = '0;
      WE       = 1'b0;
      RSP_VLD  = (state == RESP);
      capture  = 1'b0;
      cap_data = '0;
      cap_err  = 1'b0;
`ifdef SIMPLE_BUS_MASTER_POLL_EN
      cnt_inc  = 1'b0;
`endif
      if (state == ACCESS) begin
         case (wk.op)
            2'd0: begin
               ADDR = wk.addr;
               WD   = wk.wd;
               WE   = 1'b1;
            end
            2'd1: begin
               ADDR     = wk.addr;
               capture  = 1'b1;
               cap_data = RD;
            end
`ifdef SIMPLE_BUS_MASTER_POLL_EN
            2'd2: begin
               ADDR = wk.addr;
               if (poll_hit || poll_last) begin
                  capture  = 1'b1;
                  cap_data = RD;
                  cap_err  = !poll_hit;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
`endif
            default: begin
               capture = 1'b1;
               cap_err = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wk       <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (pop) wk <= mem[rd_ptr[AW_P-1:0]];
         if (capture) begin
            rsp_data <= cap_data;
            rsp_err  <= cap_err;
         end
      end
   end

   assign RSP_DATA = rsp_data;
   assign RSP_ERR  = rsp_err;

endmodule

// File: tb/tb_simple_bus_master.sv
// Self-checking bench for simple_bus_master: table-driven commands, a response scoreboard
// and hand-written sequences for writes, backpressure and reset.
module tb_simple_bus_master;
   localparam int ADDR_W = 32, DATA_W = 32, FIFO_D = 4, POLL_TMO = 16;
`ifdef SIMPLE_BUS_MASTER_POLL_EN
   localparam bit POLL_EN = 1'b1;
`else
   localparam bit POLL_EN = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST;
   logic              CMD_VLD, CMD_RDY, RSP_VLD, RSP_RDY, RSP_ERR, WE;
   logic [1:0]        CMD_OP;
   logic [ADDR_W-1:0] CMD_ADDR, ADDR;
   logic [DATA_W-1:0] CMD_WD, CMD_MASK, RSP_DATA, WD, RD;

   simple_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_D(FIFO_D), .POLL_TMO(POLL_TMO)) dut (
      .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_OP(CMD_OP),
      .CMD_ADDR(CMD_ADDR), .CMD_WD(CMD_WD), .CMD_MASK(CMD_MASK), .RSP_VLD(RSP_VLD),
      .RSP_RDY(RSP_RDY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .ADDR(ADDR), .WE(WE),
      .WD(WD), .RD(RD)
   );

   // clock / reset / cycle counting
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // responder model and bus activity monitors
   int cnt_1c = 0, cnt_20 = 0, we_cycles = 0, vld_cycles = 0;
   always @(posedge CLK) begin
      if (!WE && ADDR == 32'h1C) cnt_1c <= cnt_1c + 1;
      if (!WE && ADDR == 32'h20) cnt_20 <= cnt_20 + 1;
      if (WE) we_cycles <= we_cycles + 1;
      if (RSP_VLD) vld_cycles <= vld_cycles + 1;
   end

   function automatic logic [31:0] resp_of(input logic [31:0] a, input int c1c);
      case (a)
         32'h00:  return 32'h3C;
         32'h1C:  return (c1c >= 5) ? 32'h1 : 32'h0;
         32'h20:  return 32'h0;
         default: return a + 32'h100;
      endcase
   endfunction

   always_comb RD = resp_of(ADDR, cnt_1c);

   // scoreboard
   logic [DATA_W:0] exp_q[$];
   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks (called at a negedge, return at a negedge)
   task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] mask, output int acc);
      int n = 0;
      CMD_OP = op; CMD_ADDR = addr; CMD_WD = wd; CMD_MASK = mask; CMD_VLD = 1'b1;
      while (!CMD_RDY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!CMD_RDY) chk("cmd_rdy_wait", {63'd0, CMD_RDY}, 64'd1);
      acc = cyc;
      @(negedge CLK);
      CMD_VLD = 1'b0;
   endtask

   task automatic take_rsp(input string name);
      logic [DATA_W:0] e;
      if (exp_q.size() == 0) begin
         chk({name, "_sb_empty"}, 64'd1, 64'd0);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      chk({name, "_data"}, {32'd0, RSP_DATA}, {32'd0, e[DATA_W-1:0]});
      chk({name, "_err"}, {63'd0, RSP_ERR}, {63'd0, e[DATA_W]});
      RSP_RDY = 1'b1;
      @(negedge CLK);
      RSP_RDY = 1'b0;
   endtask

   task automatic wait_rsp(input int acc, input int lat, input string name);
      int n = 0;
      while (!RSP_VLD && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk({name, "_lat"}, 64'(cyc - acc), 64'(lat));
      if (RSP_VLD) take_rsp(name);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] mask, input logic [31:0] data, input logic err,
                          input int lat, input string name);
      int acc;
      exp_q.push_back({err, data});
      send(op, addr, wd, mask, acc);
      wait_rsp(acc, lat, name);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr, wd, mask, data;
      logic        err;
      int          lat;
      string       name;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int acc, n, hs, last, we0, vld0, c1c0, c20_0, accepts;
      vecs[0] = '{2'd1, 32'h00,   32'h0,   32'h0,   32'h3C,   1'b0, 3, "rd_00"};
      vecs[1] = '{2'd1, 32'h40,   32'h0,   32'h0,   32'h140,  1'b0, 3, "rd_40"};
      vecs[2] = '{2'd1, 32'h1234, 32'h0,   32'h0,   32'h1334, 1'b0, 3, "rd_1234"};
      vecs[3] = '{2'd3, 32'h08,   32'hFF,  32'hFF,  32'h0,    1'b1, 3, "op3"};
      vecs[4] = '{2'd2, 32'h30,   32'h100, 32'h100, POLL_EN ? 32'h130 : 32'h0, !POLL_EN, 3, "poll_now"};

      RST = 1'b0; CMD_VLD = 1'b0; CMD_OP = '0; CMD_ADDR = '0; CMD_WD = '0; CMD_MASK = '0;
      RSP_RDY = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_cmd_rdy", {63'd0, CMD_RDY}, 64'd1);
      chk("rst_rsp_vld", {63'd0, RSP_VLD}, 64'd0);
      chk("rst_rsp_data", {32'd0, RSP_DATA}, 64'd0);
      chk("rst_rsp_err", {63'd0, RSP_ERR}, 64'd0);
      chk("rst_bus", {WE, ADDR, WD}, 64'd0);
      RST = 1'b1;
      @(negedge CLK);

      // write timing
      vld0 = vld_cycles;
      send(2'd0, 32'h04, 32'hA5, 32'h0, acc);
      chk("wr_n1_we", {63'd0, WE}, 64'd0);
      @(negedge CLK);
      chk("wr_n2_cycle", 64'(cyc - acc), 64'd2);
      chk("wr_n2_bus", {31'd0, WE, ADDR}, {31'd0, 1'b1, 32'h04});
      chk("wr_n2_wd", {32'd0, WD}, 64'hA5);
      @(negedge CLK);
      chk("wr_n3_we", {63'd0, WE}, 64'd0);
      repeat (4) @(negedge CLK);
      chk("wr_no_rsp", 64'(vld_cycles - vld0), 64'd0);

      // read held under backpressure
      we0 = we_cycles;
      exp_q.push_back({1'b0, 32'h3C});
      send(2'd1, 32'h00, 32'h0, 32'h0, acc);
      chk("rd_n1_vld", {63'd0, RSP_VLD}, 64'd0);
      @(negedge CLK);
      chk("rd_n2_vld", {63'd0, RSP_VLD}, 64'd0);
      @(negedge CLK);
      chk("rd_n3_vld", {63'd0, RSP_VLD}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("rd_hold", {31'd0, RSP_VLD, RSP_ERR, RSP_DATA[30:0]}, {31'd0, 1'b1, 1'b0, 31'h3C});
         @(negedge CLK);
      end
      take_rsp("rd_held");

      // table-driven commands
      for (int i = 0; i < 5; i++)
         run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].mask, vecs[i].data,
                 vecs[i].err, vecs[i].lat, vecs[i].name);

      // poll hit on the 6th read
      c1c0 = cnt_1c;
      run_cmd(2'd2, 32'h1C, 32'h1, 32'h1, POLL_EN ? 32'h1 : 32'h0, !POLL_EN,
              POLL_EN ? 8 : 3, "poll_hit");
      chk("poll_hit_reads", 64'(cnt_1c - c1c0), POLL_EN ? 64'd6 : 64'd0);

      // poll timeout
      c20_0 = cnt_20;
      run_cmd(2'd2, 32'h20, 32'h80, 32'h80, 32'h0, 1'b1,
              POLL_EN ? 2 + POLL_TMO : 3, "poll_tmo");
      chk("poll_tmo_reads", 64'(cnt_20 - c20_0), POLL_EN ? 64'(POLL_TMO) : 64'd0);
      chk("no_we_on_reads", 64'(we_cycles - we0), 64'd0);

      // backpressure and ordering
      RSP_RDY = 1'b0; accepts = 0; CMD_OP = 2'd1; CMD_WD = '0; CMD_MASK = '0;
      for (int i = 0; i < 8; i++) begin
         CMD_ADDR = 32'(i * 4);
         if (!CMD_RDY) break;
         CMD_VLD = 1'b1;
         exp_q.push_back({1'b0, resp_of(32'(i * 4), 0)});
         @(negedge CLK);
         accepts++;
      end
      CMD_VLD = 1'b0;
      chk("bp_accepts", 64'(accepts), 64'd5);
      repeat (3) @(negedge CLK);
      chk("bp_cmd_rdy_low", {63'd0, CMD_RDY}, 64'd0);
      RSP_RDY = 1'b1; hs = 0; last = -1; n = 0;
      while (hs < 5 && n < 60) begin
         if (RSP_VLD) begin
            logic [DATA_W:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk("bp_rsp", {31'd0, RSP_ERR, RSP_DATA}, {31'd0, e});
            if (last >= 0) chk("bp_gap", 64'(cyc - last), 64'd3);
            last = cyc;
            hs++;
         end
         @(negedge CLK);
         n++;
      end
      RSP_RDY = 1'b0;
      chk("bp_handshakes", 64'(hs), 64'd5);

      // reset mid-operation
      exp_q.delete();
      send(2'd2, 32'h20, 32'h80, 32'h80, acc);
      send(2'd1, 32'h44, 32'h0, 32'h0, n);
      while (cyc < acc + 4) @(negedge CLK);
      chk("rst_pre_addr", {32'd0, ADDR}, POLL_EN ? 64'h20 : 64'h0);
      chk("rst_pre_vld", {63'd0, RSP_VLD}, POLL_EN ? 64'd0 : 64'd1);
      #2 RST = 1'b0;
      #1;
      chk("rst_mid_bus", {31'd0, WE, ADDR}, 64'd0);
      chk("rst_mid_vld_rdy", {62'd0, RSP_VLD, CMD_RDY}, 64'd1);
      @(negedge CLK);
      RST = 1'b1;
      vld0 = vld_cycles;
      repeat (4) @(negedge CLK);
      chk("rst_no_stale", 64'(vld_cycles - vld0), 64'd0);
      run_cmd(2'd1, 32'h40, 32'h0, 32'h0, 32'h140, 1'b0, 3, "rd_after_rst");
      repeat (4) @(negedge CLK);
      chk("end_idle", {63'd0, RSP_VLD}, 64'd0);
      chk("end_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
